// File: rtl/channelized_dds_sequencer_pkg.sv
// Shared types for the DDS sequencer: DDS control word, table entry and FSM states.
// Types only; no latency or flow control.
package channelized_dds_sequencer_pkg;

   localparam int DDS_NUM_CHANNELS        = 16;
   localparam int DDS_CHANNEL_INDEX_WIDTH = $clog2(DDS_NUM_CHANNELS);

   typedef enum logic [1:0] {
      dds_control_type_none      = 2'd0,
      dds_control_type_lfsr      = 2'd1,
      dds_control_type_sin_sweep = 2'd2,
      dds_control_type_sin_step  = 2'd3
   } dds_control_type_t;

   typedef struct packed {
      logic [7:0]  gain;
      logic [15:0] initial_phase;
   } dds_setup_data_t;

   typedef struct packed {
      logic signed [15:0] sweep_start;
      logic signed [15:0] sweep_stop;
      logic [15:0]        phase_inc;
   } dds_control_data_t;

   typedef struct packed {
      logic                               valid;
      logic [DDS_CHANNEL_INDEX_WIDTH-1:0] channel_index;
      dds_setup_data_t                    setup_data;
      dds_control_type_t                  control_type;
      dds_control_data_t                  control_data;
   } dds_control_t;

   typedef struct packed {
      logic              enable;
      dds_setup_data_t   setup_data;
      dds_control_type_t control_type;
      dds_control_data_t control_data;
   } dds_sequencer_entry_t;

   // Table payload without the enable bit, which lives in a resettable vector.
   typedef struct packed {
      dds_setup_data_t   setup_data;
      dds_control_type_t control_type;
      dds_control_data_t control_data;
   } dds_sequencer_payload_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_ACTIVE = 2'd2,
      S_CLEAR  = 2'd3
   } dds_sequencer_state_t;

endpackage

// File: rtl/channelized_dds_sequencer_table.sv
// Per-channel program table: one write port, one read port with 1-cycle registered latency.
// No backpressure; only the enable bits are reset, payload powers up undefined.
module channelized_dds_sequencer_table
   import channelized_dds_sequencer_pkg::*;
#(
   parameter int NUM_CHANNELS = DDS_NUM_CHANNELS,
   parameter int ADDR_WIDTH   = $clog2(NUM_CHANNELS)
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    wr_en_i,
   input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
   input  dds_sequencer_entry_t    wr_entry_i,
   input  logic                    rd_en_i,
   input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
   output dds_sequencer_entry_t    rd_entry_o
);

   dds_sequencer_payload_t mem_q [NUM_CHANNELS];
   dds_sequencer_payload_t rd_payload_q;
   logic [NUM_CHANNELS-1:0] enable_q;
   logic                    rd_enable_q;

   always_ff @(posedge Clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= '{setup_data:   wr_entry_i.setup_data,
                               control_type: wr_entry_i.control_type,
                               control_data: wr_entry_i.control_data};
      end
      if (rd_en_i) begin
         rd_payload_q <= mem_q[rd_addr_i];
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         enable_q    <= '0;
         rd_enable_q <= 1'b0;
      end else begin
         if (wr_en_i) begin
            enable_q[wr_addr_i] <= wr_entry_i.enable;
         end
         if (rd_en_i) begin
            rd_enable_q <= enable_q[rd_addr_i];
         end
      end
   end

   always_comb begin
      rd_entry_o.enable       = rd_enable_q;
      rd_entry_o.setup_data   = rd_payload_q.setup_data;
      rd_entry_o.control_type = rd_payload_q.control_type;
      rd_entry_o.control_data = rd_payload_q.control_data;
   end

endmodule

// File: rtl/channelized_dds_sequencer.sv
// Streams the channel table into the DDS on dwell start, then gates transmit; sweeps all channels to none on stop.
// Writes lag the start pulse by 2 cycles, one channel per cycle; no backpressure, host writes dropped while busy.
module channelized_dds_sequencer
   import channelized_dds_sequencer_pkg::*;
#(
   parameter int NUM_CHANNELS        = DDS_NUM_CHANNELS,
   parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS)
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           Cfg_valid,
   input  logic [CHANNEL_INDEX_WIDTH-1:0] Cfg_channel_index,
   input  dds_sequencer_entry_t           Cfg_entry,
   input  logic                           Dwell_start,
   input  logic                           Dwell_stop,
   output dds_control_t                   Control_data,
   output logic                           Dwell_active_transmit,
   output logic                           Busy,
   output logic                           Done,
   output logic                           Cfg_error
);

   localparam int CNT_WIDTH = CHANNEL_INDEX_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] LAST_CHANNEL  = CNT_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [CNT_WIDTH-1:0] CHANNEL_COUNT = CNT_WIDTH'(NUM_CHANNELS);

   dds_sequencer_state_t state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic stop_pending_q, stop_pending_d;
   logic tx_q, tx_d;
   logic out_vld_q, out_vld_d;
   logic out_clear_q, out_clear_d;
   logic [CHANNEL_INDEX_WIDTH-1:0] out_idx_q, out_idx_d;
   logic done_q, done_d;
   logic cfg_err_q, cfg_err_d;

   logic tbl_wr_en;
   logic tbl_rd_en;
   dds_sequencer_entry_t tbl_rd_entry;

   channelized_dds_sequencer_table #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .ADDR_WIDTH   (CHANNEL_INDEX_WIDTH)
   ) u_table (
      .Clk        (Clk),
      .Rst        (Rst),
      .wr_en_i    (tbl_wr_en),
      .wr_addr_i  (Cfg_channel_index),
      .wr_entry_i (Cfg_entry),
      .rd_en_i    (tbl_rd_en),
      .rd_addr_i  (cnt_q[CHANNEL_INDEX_WIDTH-1:0]),
      .rd_entry_o (tbl_rd_entry)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         stop_pending_q <= 1'b0;
         tx_q           <= 1'b0;
         out_vld_q      <= 1'b0;
         out_clear_q    <= 1'b0;
         out_idx_q      <= '0;
         done_q         <= 1'b0;
         cfg_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stop_pending_q <= stop_pending_d;
         tx_q           <= tx_d;
         out_vld_q      <= out_vld_d;
         out_clear_q    <= out_clear_d;
         out_idx_q      <= out_idx_d;
         done_q         <= done_d;
         cfg_err_q      <= cfg_err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      stop_pending_d = stop_pending_q;
      tx_d           = 1'b0;
      out_vld_d      = 1'b0;
      out_clear_d    = 1'b0;
      out_idx_d      = '0;
      done_d         = 1'b0;
      tbl_rd_en      = 1'b0;
      tbl_wr_en      = Cfg_valid && (state_q == S_IDLE);
      cfg_err_d      = Cfg_valid && (state_q != S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (Dwell_start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
            end
         end
         S_LOAD: begin
            tbl_rd_en = 1'b1;
            out_vld_d = 1'b1;
            out_idx_d = cnt_q[CHANNEL_INDEX_WIDTH-1:0];
            if (Dwell_stop) begin
               stop_pending_d = 1'b1;
            end
            if (cnt_q == LAST_CHANNEL) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         S_ACTIVE: begin
            // A stop latched during load still lets transmit rise for one cycle first.
            if (Dwell_stop || (stop_pending_q && tx_q)) begin
               state_d     = S_CLEAR;
               out_vld_d   = 1'b1;
               out_clear_d = 1'b1;
               out_idx_d   = '0;
               cnt_d       = CNT_WIDTH'(1);
            end else begin
               tx_d = 1'b1;
            end
         end
         S_CLEAR: begin
            if (cnt_q == CHANNEL_COUNT) begin
               state_d        = S_IDLE;
               done_d         = 1'b1;
               stop_pending_d = 1'b0;
               cnt_d          = '0;
            end else begin
               out_vld_d   = 1'b1;
               out_clear_d = 1'b1;
               out_idx_d   = cnt_q[CHANNEL_INDEX_WIDTH-1:0];
               cnt_d       = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      Control_data = '0;
      if (out_vld_q) begin
         Control_data.valid         = 1'b1;
         Control_data.channel_index = DDS_CHANNEL_INDEX_WIDTH'(out_idx_q);
         if (!out_clear_q && tbl_rd_entry.enable) begin
            Control_data.setup_data   = tbl_rd_entry.setup_data;
            Control_data.control_type = tbl_rd_entry.control_type;
            Control_data.control_data = tbl_rd_entry.control_data;
         end
      end
   end

   assign Dwell_active_transmit = tx_q;
   assign Busy                  = (state_q != S_IDLE);
   assign Done                  = done_q;
   assign Cfg_error             = cfg_err_q;

endmodule

// File: tb/tb_channelized_dds_sequencer.sv
// Directed bench for channelized_dds_sequencer: table-driven config/load vectors plus hand-written dwell sequences.
module tb_channelized_dds_sequencer;
   import channelized_dds_sequencer_pkg::*;

   localparam int N = 16;

   logic                 Clk = 1'b0;
   logic                 Rst;
   logic                 Cfg_valid;
   logic [3:0]           Cfg_channel_index;
   dds_sequencer_entry_t Cfg_entry;
   logic                 Dwell_start;
   logic                 Dwell_stop;
   dds_control_t         Control_data;
   logic                 Dwell_active_transmit;
   logic                 Busy;
   logic                 Done;
   logic                 Cfg_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      dds_control_type_t t;
      dds_setup_data_t   s;
      dds_control_data_t d;
   } exp_t;

   typedef struct {
      int                   ch;
      dds_sequencer_entry_t cfg;
      exp_t                 exp;
   } vec_t;

   vec_t vecs [3];
   exp_t exp_tbl [N];
   exp_t none_exp;

   channelized_dds_sequencer dut (
      .Clk                   (Clk),
      .Rst                   (Rst),
      .Cfg_valid             (Cfg_valid),
      .Cfg_channel_index     (Cfg_channel_index),
      .Cfg_entry             (Cfg_entry),
      .Dwell_start           (Dwell_start),
      .Dwell_stop            (Dwell_stop),
      .Control_data          (Control_data),
      .Dwell_active_transmit (Dwell_active_transmit),
      .Busy                  (Busy),
      .Done                  (Done),
      .Cfg_error             (Cfg_error)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic dds_control_t exp_ctrl(input int c, input exp_t e);
      dds_control_t r;
      r               = '0;
      r.valid         = 1'b1;
      r.channel_index = 4'(c);
      r.setup_data    = e.s;
      r.control_type  = e.t;
      r.control_data  = e.d;
      return r;
   endfunction

   // Pulses Dwell_start, checks the 16 load writes, then the first transmit cycle.
   task automatic run_load(input string tag, input int stop_at);
      Dwell_start = 1'b1;
      step();
      Dwell_start = 1'b0;
      Cfg_valid   = 1'b0;
      check($sformatf("%s busy", tag), Busy, 1);
      check($sformatf("%s gap", tag), Control_data, 0);
      for (int c = 0; c < N; c++) begin
         step();
         Dwell_stop = 1'b0;
         check($sformatf("%s load ch%0d", tag, c), Control_data, exp_ctrl(c, exp_tbl[c]));
         check($sformatf("%s tx low ch%0d", tag, c), Dwell_active_transmit, 0);
         if (c == stop_at) Dwell_stop = 1'b1;
      end
      step();
      check($sformatf("%s tx high", tag), Dwell_active_transmit, 1);
      check($sformatf("%s post-load idle bus", tag), Control_data, 0);
   endtask

   // Entered on the cycle that shows the ch0 clear write.
   task automatic check_clear(input string tag);
      for (int c = 0; c < N; c++) begin
         check($sformatf("%s clear ch%0d", tag, c), Control_data, exp_ctrl(c, none_exp));
         check($sformatf("%s clear tx ch%0d", tag, c), Dwell_active_transmit, 0);
         check($sformatf("%s clear busy ch%0d", tag, c), Busy, 1);
         check($sformatf("%s clear done ch%0d", tag, c), Done, 0);
         step();
      end
      check($sformatf("%s done", tag), Done, 1);
      check($sformatf("%s idle busy", tag), Busy, 0);
      check($sformatf("%s idle bus", tag), Control_data, 0);
      step();
      check($sformatf("%s done once", tag), Done, 0);
   endtask

   task automatic stop_and_clear(input string tag);
      Dwell_stop = 1'b1;
      step();
      Dwell_stop = 1'b0;
      check_clear(tag);
   endtask

   initial begin
      none_exp = '{t: dds_control_type_none, s: '0, d: '0};
      vecs[0] = '{ch: 0,
                  cfg: '{enable: 1'b1, setup_data: '{gain: 8'h40, initial_phase: 16'h0000},
                         control_type: dds_control_type_sin_sweep,
                         control_data: '{sweep_start: -16'sd1000, sweep_stop: 16'sd1000, phase_inc: 16'd10}},
                  exp: '{t: dds_control_type_sin_sweep, s: '{gain: 8'h40, initial_phase: 16'h0000},
                         d: '{sweep_start: -16'sd1000, sweep_stop: 16'sd1000, phase_inc: 16'd10}}};
      vecs[1] = '{ch: 1,
                  cfg: '{enable: 1'b0, setup_data: '{gain: 8'h11, initial_phase: 16'h2222},
                         control_type: dds_control_type_lfsr,
                         control_data: '{sweep_start: 16'sd5, sweep_stop: 16'sd6, phase_inc: 16'd7}},
                  exp: '{t: dds_control_type_none, s: '0, d: '0}};
      vecs[2] = '{ch: 3,
                  cfg: '{enable: 1'b1, setup_data: '{gain: 8'h7F, initial_phase: 16'h1234},
                         control_type: dds_control_type_sin_step,
                         control_data: '{sweep_start: 16'sd0, sweep_stop: 16'sd0, phase_inc: 16'd250}},
                  exp: '{t: dds_control_type_sin_step, s: '{gain: 8'h7F, initial_phase: 16'h1234},
                         d: '{sweep_start: 16'sd0, sweep_stop: 16'sd0, phase_inc: 16'd250}}};
      for (int i = 0; i < N; i++) exp_tbl[i] = none_exp;
      for (int v = 0; v < 3; v++) exp_tbl[vecs[v].ch] = vecs[v].exp;

      Rst = 1'b1; Cfg_valid = 1'b0; Cfg_channel_index = '0; Cfg_entry = '0;
      Dwell_start = 1'b0; Dwell_stop = 1'b0;
      step();
      step();
      check("reset bus", Control_data, 0);
      check("reset tx", Dwell_active_transmit, 0);
      check("reset busy", Busy, 0);
      check("reset done", Done, 0);
      check("reset cfg_error", Cfg_error, 0);
      Rst = 1'b0;
      Dwell_stop = 1'b1;
      step();
      Dwell_stop = 1'b0;
      check("stop ignored in idle", Busy, 0);

      for (int v = 0; v < 3; v++) begin
         Cfg_valid = 1'b1;
         Cfg_channel_index = 4'(vecs[v].ch);
         Cfg_entry = vecs[v].cfg;
         step();
         Cfg_valid = 1'b0;
         check($sformatf("idle write %0d no error", v), Cfg_error, 0);
      end

      run_load("t1", -1);

      Cfg_valid = 1'b1;
      Cfg_channel_index = 4'd3;
      Cfg_entry = '{enable: 1'b1, setup_data: '{gain: 8'h01, initial_phase: 16'h0001},
                    control_type: dds_control_type_lfsr,
                    control_data: '{sweep_start: 16'sd0, sweep_stop: 16'sd0, phase_inc: 16'd99}};
      step();
      Cfg_valid = 1'b0;
      check("t4 cfg_error pulse", Cfg_error, 1);
      step();
      check("t4 cfg_error single", Cfg_error, 0);
      Dwell_start = 1'b1;
      step();
      Dwell_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t4 restart ignored bus %0d", k), Control_data, 0);
         check($sformatf("t4 restart ignored tx %0d", k), Dwell_active_transmit, 1);
         step();
      end

      stop_and_clear("t2");

      run_load("t4", -1);
      stop_and_clear("t4");

      run_load("t3", 3);
      step();
      check_clear("t3");

      Dwell_start = 1'b1;
      step();
      Dwell_start = 1'b0;
      for (int k = 0; k < 7; k++) step();
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      check("t5 reset bus", Control_data, 0);
      check("t5 reset busy", Busy, 0);
      check("t5 reset tx", Dwell_active_transmit, 0);
      for (int i = 0; i < N; i++) exp_tbl[i] = none_exp;
      run_load("t5", -1);
      stop_and_clear("t5");

      exp_tbl[7] = '{t: dds_control_type_lfsr, s: '{gain: 8'h22, initial_phase: 16'h0040},
                     d: '{sweep_start: 16'sd0, sweep_stop: 16'sd0, phase_inc: 16'd1000}};
      Cfg_valid = 1'b1;
      Cfg_channel_index = 4'd7;
      Cfg_entry = '{enable: 1'b1, setup_data: '{gain: 8'h22, initial_phase: 16'h0040},
                    control_type: dds_control_type_lfsr,
                    control_data: '{sweep_start: 16'sd0, sweep_stop: 16'sd0, phase_inc: 16'd1000}};
      run_load("t6", -1);
      check("t6 no cfg_error", Cfg_error, 0);
      stop_and_clear("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/channelized_dds_sequencer.md
Name: channelized_dds_sequencer

Overview:
- Sequences the Control_data port and the Dwell_active_transmit input of channelized_dds.
- Holds a per-channel table of DDS programs (setup, control type, control data), written by the host while idle.
- On dwell start, streams the table into the DDS one channel per cycle, then asserts transmit.
- On dwell stop, deasserts transmit and streams dds_control_type_none to every channel, then reports done.

Parameters:
- NUM_CHANNELS, 16, number of DDS channels and table entries.
- CHANNEL_INDEX_WIDTH, $clog2(NUM_CHANNELS), width of channel index.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset; synchronous, active-high.
- Cfg_valid  in  1  table write strobe.
- Cfg_channel_index  in  CHANNEL_INDEX_WIDTH  entry to write.
- Cfg_entry  in  dds_sequencer_entry_t  {enable, setup_data, control_type, control_data}.
- Dwell_start  in  1  single-cycle start pulse.
- Dwell_stop  in  1  single-cycle stop pulse.
- Control_data  out  dds_control_t  to channelized_dds Control_data.
- Dwell_active_transmit  out  1  to channelized_dds Dwell_active_transmit.
- Busy  out  1  high in any state other than S_IDLE.
- Done  out  1  one-cycle pulse when the clear sweep completes.
- Cfg_error  out  1  one-cycle pulse when a config write is dropped.

Behaviour:
- **Reset values:** S_IDLE; Control_data.valid=0; Dwell_active_transmit=0; Busy=0; Done=0; Cfg_error=0; all table enable bits = 0. Table payload fields are not reset.
- **Table:** NUM_CHANNELS entries. Write port is used only in S_IDLE; read port has 1-cycle registered latency.
- **Config writes:**
  - Cfg_valid in S_IDLE writes the entry the next cycle.
  - Cfg_valid in any other state is dropped and pulses Cfg_error the following cycle.
  - Cfg_valid and Dwell_start in the same S_IDLE cycle: the write commits first; the load sees the new entry.
- **FSM:** S_IDLE -> S_LOAD -> S_ACTIVE -> S_CLEAR -> S_IDLE.
- **S_IDLE:** Dwell_start -> S_LOAD with counter=0. Dwell_stop is ignored.
- **S_LOAD:**
  - Counter 0..NUM_CHANNELS-1 issues one table read per cycle.
  - One cycle later, Control_data.valid=1 with channel_index=counter, carrying the entry fields.
  - A disabled entry emits control_type=dds_control_type_none, setup_data='0, control_data='0.
  - After the last read -> S_ACTIVE.
  - Dwell_stop seen during S_LOAD is latched (stop_pending); the load still completes.
- **S_ACTIVE:**
  - Dwell_active_transmit=1 starting the cycle after the last load write.
  - Dwell_stop, or stop_pending set -> S_CLEAR; Dwell_active_transmit drops in the same transition cycle.
  - Dwell_start is ignored.
- **S_CLEAR:**
  - Counter 0..NUM_CHANNELS-1 emits valid writes with control_type=none, zero setup and zero control data, one per cycle, using the same output timing as S_LOAD.
  - After the last write -> S_IDLE and Done=1 for one cycle; stop_pending is cleared.
- **Timing (Dwell_start sampled at cycle T):**
  - Control writes appear at T+2 .. T+NUM_CHANNELS+1.
  - Dwell_active_transmit=1 from T+NUM_CHANNELS+2.
- **Clear timing (Dwell_stop sampled at cycle S in S_ACTIVE):**
  - Transmit is low from S+1.
  - Clear writes appear at S+1 .. S+NUM_CHANNELS.
  - Done pulses at S+NUM_CHANNELS+1.
- **Back-to-back writes:** no bubbles within a sweep; exactly NUM_CHANNELS valid writes per sweep.
- **Counter:** width CHANNEL_INDEX_WIDTH+1 to terminate cleanly when NUM_CHANNELS is a power of two.
- **Output register:** when Control_data.valid=0, all other Control_data fields are '0.
- **Reset mid-operation:** the next cycle everything returns to reset values. No partial sweep continues; the DDS is left as-is (software re-issues a dwell).

Decomposition:
- dsp_pkg additions:
  - dds_sequencer_entry_t: enable, setup_data, control_type, control_data, reusing the existing dds_control field types.
  - dds_sequencer_state_t enum.
- Sub-module: dds_sequencer_table, a simple dual-port RAM (1 write, 1 registered read) with a separate resettable enable-bit vector.

Test Plan:
1. Write ch0 sin_sweep(-1000,1000,10) enabled, ch1..15 disabled; pulse Dwell_start at T -> T+2 ch0 sin_sweep with matching data, T+3..T+17 ch1..15 type none, transmit=1 from T+18.
2. In S_ACTIVE pulse Dwell_stop at S -> transmit=0 at S+1, 16 none writes ch0..15 at S+1..S+16, Done at S+17, Busy=0 after.
3. Pulse Dwell_stop at T+5 during load -> load completes all 16 writes, transmit high for exactly 1 cycle, then clear sweep and Done.
4. Cfg_valid in S_ACTIVE for ch3 -> Cfg_error pulse; the next dwell loads the old ch3 entry. A second Dwell_start during S_ACTIVE is ignored (no extra writes).
5. Assert Rst at T+8 mid-load -> next cycle valid=0, Busy=0, transmit=0; a subsequent start loads ch0..15 with all entries disabled (type none).
6. Cfg_valid ch7 lfsr(1000) and Dwell_start in the same cycle -> ch7 write carries lfsr with phase_inc 1000.
